// File: rtl/uart_tx_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine_if
// Description : Byte-side handshake and serial-line bundle for uart_tx_engine.
//               The parity_mode signal exists only when UART_TX_PARITY_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_engine_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
`ifdef UART_TX_PARITY_EN
    logic [1:0]           parity_mode;
`endif
    logic                 tx;
    logic                 busy;
    logic                 tx_done;

`ifdef UART_TX_PARITY_EN
    // Byte producer side
    modport master (
        output tx_data, tx_valid, parity_mode,
        input  tx_ready, tx, busy, tx_done
    );
    // Transmit engine side
    modport slave (
        input  tx_data, tx_valid, parity_mode,
        output tx_ready, tx, busy, tx_done
    );
`else
    // Byte producer side
    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx, busy, tx_done
    );
    // Transmit engine side
    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx, busy, tx_done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine
// Description : Single-clock UART transmitter. Bit timing is a sys_clk tick
//               count (CLK_DIV cycles per bit), framing is a small FSM and the
//               payload leaves LSB first from a shift register. The optional
//               parity bit is built only when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic            sys_clk,
    input  logic            rst,
    uart_tx_engine_if.slave bus
);

    localparam int C_TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int C_BIT_W  = 4;

    localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(CLK_DIV - 1);
    localparam logic [C_BIT_W-1:0]  C_DATA_LAST = C_BIT_W'(DATA_BITS - 1);
    localparam logic [C_BIT_W-1:0]  C_STOP_LAST = C_BIT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_TICK_W-1:0]  r_tick;
    logic [C_TICK_W-1:0]  w_tick_nxt;
    logic [C_BIT_W-1:0]   r_bit_cnt;
    logic [C_BIT_W-1:0]   w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_accept;
    logic                 w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 r_par_en;
    logic                 w_par_en_nxt;
    logic                 r_par_bit;
    logic                 w_par_bit_nxt;
`endif

    // Ready is withheld during reset so no byte can slip in on a reset edge
    assign bus.tx_ready = (r_state == S_IDLE) && !rst;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.tx       = r_tx;
    assign bus.tx_done  = r_done;

    assign w_accept  = bus.tx_valid && bus.tx_ready;
    assign w_bit_end = (r_tick == C_TICK_LAST);

    // Next-state, counter, shift and line-value decode
    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = w_bit_end ? '0 : r_tick + 1'b1;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_done_nxt    = 1'b0;
        w_tx_nxt      = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
`endif

        case (r_state)
            S_IDLE: begin
                w_tick_nxt    = '0;
                w_bit_cnt_nxt = '0;
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = bus.tx_data;
`ifdef UART_TX_PARITY_EN
                    // Modes 01 (even) and 10 (odd) add a bit; 00 and 11 do not.
                    // Odd parity is even parity inverted, i.e. XOR with mode[1].
                    w_par_en_nxt  = (bus.parity_mode == 2'b01) ||
                                    (bus.parity_mode == 2'b10);
                    w_par_bit_nxt = (^bus.tx_data) ^ bus.parity_mode[1];
`endif
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == C_DATA_LAST) begin
                        w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt   = r_par_en ? S_PARITY : S_STOP;
`else
                        w_state_nxt   = S_STOP;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_STOP;
                    w_bit_cnt_nxt = '0;
                end
            end
`endif

            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == C_STOP_LAST) begin
                        w_state_nxt   = S_IDLE;
                        w_bit_cnt_nxt = '0;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_tick_nxt    = '0;
                w_bit_cnt_nxt = '0;
            end
        endcase

        // The line is registered, so it is decoded from the state being entered
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = r_par_bit;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // State, counters, shift register and registered line/done outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_done    <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_engine
// Description : Directed self-checking bench for uart_tx_engine. Instance A is
//               CLK_DIV=4/8 data/1 stop, instance B is CLK_DIV=3/5 data/2 stop.
//               Parity frames are exercised when UART_TX_PARITY_EN is defined.
//               Inputs change on the falling edge or 1 ns after the rising
//               edge; sample s<k> is taken 1 ns after the k-th rising edge
//               following the accept edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

    logic sys_clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic cap_tx    [0:127];
    logic cap_busy  [0:127];
    logic cap_done  [0:127];
    logic cap_ready [0:127];

    uart_tx_engine_if #(.DATA_BITS(8)) ifa ();
    uart_tx_engine_if #(.DATA_BITS(5)) ifb ();

    uart_tx_engine #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (ifa)
    );

    uart_tx_engine #(.CLK_DIV(3), .DATA_BITS(5), .STOP_BITS(2)) dut_b (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (ifb)
    );

    // 10 ns system clock
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present a byte to A and return 1 ns after the accept edge (sample s0)
    task automatic start_a(input logic [7:0] data);
        @(negedge sys_clk);
        ifa.tx_data  = data;
        ifa.tx_valid = 1'b1;
        chk("a_ready_before_accept", ifa.tx_ready, 1'b1);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_b(input logic [4:0] data);
        @(negedge sys_clk);
        ifb.tx_data  = data;
        ifb.tx_valid = 1'b1;
        chk("b_ready_before_accept", ifb.tx_ready, 1'b1);
        @(posedge sys_clk);
        #1;
    endtask

    // Record n samples of A; optionally change tx_data / drop tx_valid at a sample
    task automatic cap_a(input int n, input int chg_k, input logic [7:0] chg_val,
                         input int drop_k);
        for (int k = 0; k < n; k++) begin
            cap_tx[k]    = ifa.tx;
            cap_busy[k]  = ifa.busy;
            cap_done[k]  = ifa.tx_done;
            cap_ready[k] = ifa.tx_ready;
            if (k == chg_k)  ifa.tx_data  = chg_val;
            if (k == drop_k) ifa.tx_valid = 1'b0;
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic cap_b(input int n);
        for (int k = 0; k < n; k++) begin
            cap_tx[k]    = ifb.tx;
            cap_busy[k]  = ifb.busy;
            cap_done[k]  = ifb.tx_done;
            cap_ready[k] = ifb.tx_ready;
            if (k == 0) ifb.tx_valid = 1'b0;
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Compare a captured frame starting at sample 'base' against the ideal waveform
    task automatic check_frame(input string tag, input int base, input int nbits,
                               input int div, input int stops, input logic [8:0] data,
                               input bit par_en, input logic par_val);
        int   len;
        int   b;
        logic e;
        len = div * (1 + nbits + int'(par_en) + stops);
        for (int s = 0; s < len; s++) begin
            b = s / div;
            if (b == 0)                           e = 1'b0;
            else if (b <= nbits)                  e = data[b-1];
            else if (par_en && (b == nbits + 1))  e = par_val;
            else                                  e = 1'b1;
            chk($sformatf("%s_tx_s%0d", tag, base + s), cap_tx[base + s], e);
            chk($sformatf("%s_busy_s%0d", tag, base + s), cap_busy[base + s], 1'b1);
            chk($sformatf("%s_done_s%0d", tag, base + s), cap_done[base + s], 1'b0);
        end
        chk($sformatf("%s_busy_end", tag), cap_busy[base + len], 1'b0);
        chk($sformatf("%s_ready_end", tag), cap_ready[base + len], 1'b1);
        chk($sformatf("%s_done_pulse", tag), cap_done[base + len], 1'b1);
        chk($sformatf("%s_done_clear", tag), cap_done[base + len + 1], 1'b0);
    endtask

    // Directed sequence
    initial begin
        logic seen_done;

        rst          = 1'b1;
        ifa.tx_data  = '0;
        ifa.tx_valid = 1'b0;
        ifb.tx_data  = '0;
        ifb.tx_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
        ifa.parity_mode = 2'b00;
        ifb.parity_mode = 2'b00;
`endif

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_a_tx", ifa.tx, 1'b1);
        chk("rst_a_busy", ifa.busy, 1'b0);
        chk("rst_a_done", ifa.tx_done, 1'b0);
        chk("rst_a_ready", ifa.tx_ready, 1'b0);
        chk("rst_b_tx", ifb.tx, 1'b1);
        chk("rst_b_ready", ifb.tx_ready, 1'b0);
        @(negedge sys_clk);
        rst = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("post_rst_a_ready", ifa.tx_ready, 1'b1);
        chk("post_rst_b_ready", ifb.tx_ready, 1'b1);
        chk("post_rst_a_tx", ifa.tx, 1'b1);

        // 0xA5: 0, 1,0,1,0,0,1,0,1, 1 at 4 cycles per bit, done at s40
        start_a(8'hA5);
        cap_a(42, -1, 8'h00, 0);
        check_frame("a5", 0, 8, 4, 1, 9'h0A5, 1'b0, 1'b0);

        // tx_valid held across two bytes: 0x00 then 0xFF, one idle cycle between
        start_a(8'h00);
        cap_a(83, 0, 8'hFF, 41);
        check_frame("b2b_first", 0, 8, 4, 1, 9'h000, 1'b0, 1'b0);
        chk("b2b_idle_gap_tx", cap_tx[40], 1'b1);
        chk("b2b_second_start_tx", cap_tx[41], 1'b0);
        check_frame("b2b_second", 41, 8, 4, 1, 9'h0FF, 1'b0, 1'b0);

        // tx_data changes to 0x3C one cycle after accepting 0xA5
        start_a(8'hA5);
        cap_a(42, 1, 8'h3C, 0);
        check_frame("chg", 0, 8, 4, 1, 9'h0A5, 1'b0, 1'b0);

        // One-cycle reset during the 4th data bit (s16..s19, bits 3 and 4 are 0)
        start_a(8'hA5);
        cap_a(17, -1, 8'h00, 0);
        chk("abort_pre_tx", cap_tx[16], 1'b0);
        chk("abort_pre_busy", cap_busy[16], 1'b1);
        @(negedge sys_clk);
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("abort_tx", ifa.tx, 1'b1);
        chk("abort_busy", ifa.busy, 1'b0);
        chk("abort_ready", ifa.tx_ready, 1'b0);
        chk("abort_done", ifa.tx_done, 1'b0);
        @(negedge sys_clk);
        rst = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("abort_ready_after", ifa.tx_ready, 1'b1);
        chk("abort_busy_after", ifa.busy, 1'b0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            seen_done = seen_done | ifa.tx_done;
            @(posedge sys_clk);
            #1;
        end
        chk("abort_no_done", seen_done, 1'b0);

        // B: 5 data bits, 2 stop bits, CLK_DIV=3, data 0x13 -> 24-cycle frame
        start_b(5'h13);
        cap_b(26);
        check_frame("b13", 0, 5, 3, 2, 9'h013, 1'b0, 1'b0);

`ifdef UART_TX_PARITY_EN
        // Even parity of 0x07 is 1
        ifa.parity_mode = 2'b01;
        start_a(8'h07);
        ifa.parity_mode = 2'b00;
        cap_a(46, -1, 8'h00, 0);
        check_frame("par_even", 0, 8, 4, 1, 9'h007, 1'b1, 1'b1);

        // Odd parity of 0x07 is 0
        ifa.parity_mode = 2'b10;
        start_a(8'h07);
        cap_a(46, -1, 8'h00, 0);
        check_frame("par_odd", 0, 8, 4, 1, 9'h007, 1'b1, 1'b0);

        // Mode 11 behaves as no parity: 40-cycle frame
        ifa.parity_mode = 2'b11;
        start_a(8'h07);
        cap_a(42, -1, 8'h00, 0);
        check_frame("par_11", 0, 8, 4, 1, 9'h007, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised UART transmit engine. It merges bit-rate timing, the framing state machine and the shift register into a single-clock block with a valid/ready byte interface. It drives the serial `tx` line of the UART and supersedes the separate baud generator and transmit FSM pair: timing is a `sys_clk` tick count, not a derived clock. Data width, stop-bit count and bit period are configurable, and parity is a compile-time option.

## Interface
- `CLK_DIV`, 434: `sys_clk` cycles per bit (≥2; 50 MHz / 115200).
- `DATA_BITS`, 8: data bits per frame, range 5–9.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `sys_clk`  in  1  sole clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  DATA_BITS  byte to send; sampled on accept.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  engine can accept a byte.
- `parity_mode`  in  2  present only with `UART_TX_PARITY_EN`: 00 none, 01 even, 10 odd, 11 treated as none; sampled on accept.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress.
- `tx_done`  out  1  one-cycle pulse after the last stop bit ends.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Accept: `tx_valid && tx_ready` on a clock edge.
  - Latches `tx_data`, and `parity_mode` when present.
  - Clears the bit counter and the tick counter.
  - Moves to START.
- `tx_ready` = (state == IDLE) && !`rst`. `busy` = (state != IDLE).
- Tick counter counts 0..CLK_DIV-1 in every non-IDLE state. The terminal count ends the current bit.
- Line value per state:
  - START: `tx`=0.
  - DATA: `tx`=shift[0], LSB first; the register shifts right at each bit end.
  - PARITY: even mode sends XOR of the data bits; odd mode sends its inverse.
  - STOP: `tx`=1.
  - IDLE: `tx`=1.
- Transitions at each bit end:
  - START → DATA.
  - DATA → DATA until DATA_BITS bits are sent, then → PARITY if parity is active, else → STOP.
  - PARITY → STOP.
  - STOP → STOP until STOP_BITS are sent, then → IDLE.
- Entering IDLE from STOP sets `tx_done` for exactly that first IDLE cycle.
- `tx_data` and `parity_mode` may change freely after accept; the frame in flight is unaffected.

## Timing
- Reset values: `tx`=1, `busy`=0, `tx_done`=0, state IDLE, counters 0.
- While `rst` is high, `tx_ready` is 0 and no accept occurs. `tx_ready` is 1 from the first cycle after `rst` is deasserted.
- Latency: the start bit appears on `tx` the cycle after the accept edge. `tx` is a registered output.
- Frame length: CLK_DIV × (1 + DATA_BITS + P + STOP_BITS) cycles, where P=1 when parity is active, else 0.
- Back-to-back frames:
  - `tx_ready` rises in the same cycle as the `tx_done` pulse.
  - An accept in that cycle starts the next start bit one cycle later.
  - The minimum inter-frame idle is therefore 1 `sys_clk` cycle of `tx`=1.
- Reset mid-frame: the frame aborts. The next cycle has `tx`=1, `busy`=0, and no `tx_done`.
- Holding `tx_valid` while busy has no effect; the byte is held until `tx_ready`.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The `parity_mode` port exists.
  - The PARITY state and parity logic are built.
  - A frame carries a parity bit when the sampled mode is 01 or 10.
- `UART_TX_PARITY_EN` undefined:
  - There is no `parity_mode` port and no PARITY state; P is always 0.
  - Frame timing is identical to a mode-00 frame of the defined build.

## Test plan
- CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, no parity. Send 0xA5 → `tx` carries 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles. `tx_done` pulses at cycle 41 after accept, and `busy` is high for 40 cycles.
- Same settings, `tx_valid` held high with two bytes 0x00 then 0xFF → the second start bit begins exactly 2 cycles after the first frame's last stop-bit cycle. There is one idle-high cycle, and the second frame is all-ones data.
- With `UART_TX_PARITY_EN`, mode 01, data 0x07 → parity bit 1. Mode 10, data 0x07 → parity bit 0. Mode 11 → no parity bit, 40-cycle frame.
- DATA_BITS=5, STOP_BITS=2, CLK_DIV=3, data 0x13 → `tx` carries 0, then 1,1,0,0,1, then 1,1 at 3 cycles per bit. Frame length is 24 cycles.
- Assert `rst` for 1 cycle during the 4th data bit → the next cycle has `tx`=1, `busy`=0, `tx_ready`=0. `tx_ready`=1 the following cycle, and no `tx_done` pulse occurs.
- Change `tx_data` to 0x3C one cycle after accepting 0xA5 → the serialized data still equals 0xA5.
